// File: rtl/alsu_rc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_rc_pkg
//  Description : Shared opcodes, entry type and counter helpers for the
//                ALSU result collector.
//  Revision    : 1.0
// ============================================================================
package alsu_rc_pkg;

    localparam int RC_OUT_W = 6;
    localparam int DROP_W   = 8;

    localparam logic [2:0] OP_OR     = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_MULT   = 3'd3;
    localparam logic [2:0] OP_SHIFT  = 3'd4;
    localparam logic [2:0] OP_ROTATE = 3'd5;

    typedef struct packed {
        logic [2:0]                 opcode;
        logic signed [RC_OUT_W-1:0] data;
    } rc_entry_t;

    // Saturating increment shared by the drop and statistics counters
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_result_collector_if
//  Description : Capture, flush and result-stream signals of the collector.
//                Stats ports exist only with ALSU_RC_STATS_EN.
//  Revision    : 1.0
// ============================================================================
interface alsu_result_collector_if #(
    parameter int DEPTH = 8,
    parameter int OUT_W = alsu_rc_pkg::RC_OUT_W
);
    logic                           op_valid;
    logic [2:0]                     op_opcode;
    logic signed [OUT_W-1:0]        alsu_out;
    logic                           flush;
    logic                           res_valid;
    logic                           res_ready;
    logic signed [OUT_W-1:0]        res_data;
    logic [2:0]                     res_opcode;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           full;
    logic [alsu_rc_pkg::DROP_W-1:0] drop_cnt;
`ifdef ALSU_RC_STATS_EN
    logic [alsu_rc_pkg::DROP_W-1:0] zero_cnt;
    logic [alsu_rc_pkg::DROP_W-1:0] neg_cnt;

    modport master (
        output op_valid, op_opcode, alsu_out, flush, res_ready,
        input  res_valid, res_data, res_opcode, count, full, drop_cnt, zero_cnt, neg_cnt
    );
    modport slave (
        input  op_valid, op_opcode, alsu_out, flush, res_ready,
        output res_valid, res_data, res_opcode, count, full, drop_cnt, zero_cnt, neg_cnt
    );
`else
    modport master (
        output op_valid, op_opcode, alsu_out, flush, res_ready,
        input  res_valid, res_data, res_opcode, count, full, drop_cnt
    );
    modport slave (
        input  op_valid, op_opcode, alsu_out, flush, res_ready,
        output res_valid, res_data, res_opcode, count, full, drop_cnt
    );
`endif
endinterface
`default_nettype wire

// File: rtl/alsu_rc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_rc_fifo
//  Description : First-word-fall-through storage for collected results;
//                flush has priority over push and pop.
//  Revision    : 1.0
// ============================================================================
module alsu_rc_fifo
    import alsu_rc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  rc_entry_t                  wr_entry,
    output rc_entry_t                  rd_entry,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rc_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            r_mem[r_wr_ptr] <= wr_entry;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (push && !pop)      r_count <= r_count + CNT_W'(1);
            else if (pop && !push) r_count <= r_count - CNT_W'(1);
        end
    end

    assign rd_entry = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alsu_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_result_collector
//  Description : Aligns opcodes with the ALSU's delayed result and buffers
//                them; optional zero/negative counters via ALSU_RC_STATS_EN.
//  Revision    : 1.0
// ============================================================================
module alsu_result_collector
    import alsu_rc_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 2,
    parameter int OUT_W   = RC_OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    alsu_result_collector_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [LATENCY-1:0]      r_tag_valid;
    logic [LATENCY-1:0][2:0] r_tag_op;
    logic [DROP_W-1:0]       r_drop_cnt;

    logic             w_wr;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    rc_entry_t        w_wr_entry;
    rc_entry_t        w_rd_entry;

    // Tag pipeline: the opcode arrives at the last stage in the same cycle
    // as the ALSU result it produced
    always_ff @(posedge clk) begin
        if (!rst || bus.flush) begin
            r_tag_valid <= '0;
            r_tag_op    <= '0;
        end else begin
            r_tag_valid[0] <= bus.op_valid;
            r_tag_op[0]    <= bus.op_opcode;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_valid[i] <= r_tag_valid[i-1];
                r_tag_op[i]    <= r_tag_op[i-1];
            end
        end
    end

    always_comb begin
        w_wr_entry        = '0;
        w_wr_entry.opcode = r_tag_op[LATENCY-1];
        w_wr_entry.data   = bus.alsu_out;
    end

    assign w_wr   = r_tag_valid[LATENCY-1];
    assign w_pop  = !w_empty && bus.res_ready;
    assign w_push = w_wr && (!w_full || w_pop);
    assign w_drop = w_wr && w_full && !w_pop;

    alsu_rc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .push     (w_push),
        .pop      (w_pop),
        .wr_entry (w_wr_entry),
        .rd_entry (w_rd_entry),
        .count    (w_count),
        .full     (w_full),
        .empty    (w_empty)
    );

    // A write discarded by flush is not an overflow
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (!bus.flush && w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

`ifdef ALSU_RC_STATS_EN
    logic [DROP_W-1:0] r_zero_cnt;
    logic [DROP_W-1:0] r_neg_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_zero_cnt <= '0;
            r_neg_cnt  <= '0;
        end else if (w_push && !bus.flush) begin
            if (w_wr_entry.data == '0)      r_zero_cnt <= sat_inc(r_zero_cnt);
            if (w_wr_entry.data[OUT_W-1])   r_neg_cnt  <= sat_inc(r_neg_cnt);
        end
    end

    assign bus.zero_cnt = r_zero_cnt;
    assign bus.neg_cnt  = r_neg_cnt;
`endif

    assign bus.res_valid  = !w_empty;
    assign bus.res_data   = w_empty ? '0 : w_rd_entry.data;
    assign bus.res_opcode = w_empty ? 3'd0 : w_rd_entry.opcode;
    assign bus.count      = w_count;
    assign bus.full       = w_full;
    assign bus.drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
